// File: rtl/car_pkg.sv
// Shared constants for the steering path: one-hot key masks used by both the
// PS/2 decoder and car_ctl, the Set-2 scan codes we react to, and the
// receiver FSM state type.
package car_pkg;

    // One-hot direction masks; bit positions match the key output.
    localparam logic [3:0] KEY_UP    = 4'b0001;
    localparam logic [3:0] KEY_DOWN  = 4'b0010;
    localparam logic [3:0] KEY_LEFT  = 4'b0100;
    localparam logic [3:0] KEY_RIGHT = 4'b1000;

    // Prefix bytes.
    localparam logic [7:0] SC_EXT  = 8'hE0;
    localparam logic [7:0] SC_BRK  = 8'hF0;

    // Keyboard overrun / error codes: drop every held key.
    localparam logic [7:0] SC_OVR0 = 8'h00;
    localparam logic [7:0] SC_OVR1 = 8'hFF;

    // Arrow keys (only valid after an E0 prefix).
    localparam logic [7:0] SC_X_UP    = 8'h75;
    localparam logic [7:0] SC_X_DOWN  = 8'h72;
    localparam logic [7:0] SC_X_LEFT  = 8'h6B;
    localparam logic [7:0] SC_X_RIGHT = 8'h74;

    // WASD (no prefix).
    localparam logic [7:0] SC_W = 8'h1D;
    localparam logic [7:0] SC_S = 8'h1B;
    localparam logic [7:0] SC_A = 8'h1C;
    localparam logic [7:0] SC_D = 8'h23;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_RECV  = 2'd1,
        RX_CHECK = 2'd2
    } rx_state_e;

    // Map (extended flag, scan code) to a direction mask; zero when unmapped.
    function automatic logic [3:0] key_lookup(input logic ext, input logic [7:0] code);
        logic [3:0] mask;
        mask = 4'b0000;
        if (ext) begin
            case (code)
                SC_X_UP:    mask = KEY_UP;
                SC_X_DOWN:  mask = KEY_DOWN;
                SC_X_LEFT:  mask = KEY_LEFT;
                SC_X_RIGHT: mask = KEY_RIGHT;
                default:    mask = 4'b0000;
            endcase
        end else begin
            case (code)
                SC_W:    mask = KEY_UP;
                SC_S:    mask = KEY_DOWN;
                SC_A:    mask = KEY_LEFT;
                SC_D:    mask = KEY_RIGHT;
                default: mask = 4'b0000;
            endcase
        end
        return mask;
    endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// Bundle of the keyboard lines and the decoder's results. The keyboard side
// (or a bus model) is the master; the decoder is the slave.
interface ps2_key_decoder_if;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] key;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  key,
        input  rx_data,
        input  rx_valid,
        input  rx_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output key,
        output rx_data,
        output rx_valid,
        output rx_err
    );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronises both lines into pclk, debounces the
// keyboard clock, samples data on filtered falling edges and checks the
// 11-bit frame. ps2_clk is only ever treated as data.
module ps2_rx
    import car_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       pclk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [FW-1:0] FILT_LAST   = FW'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);

    logic [1:0]    clk_sync_q;
    logic [1:0]    dat_sync_q;
    logic          filt_q;
    logic          filt_prev_q;
    logic [FW-1:0] filt_cnt_q;
    logic          strobe;

    rx_state_e     state_q;
    logic [3:0]    bit_cnt_q;
    logic [9:0]    shift_q;     // samples 1..10, oldest at bit 0
    logic [TW-1:0] timer_q;
    logic [7:0]    rx_data_q;
    logic          rx_valid_q;
    logic          rx_err_q;
    logic          frame_ok;

    // Two-flop synchronisers for the asynchronous keyboard lines.
    always_ff @(posedge pclk) begin
        if (rst) begin
            clk_sync_q <= 2'b00;
            dat_sync_q <= 2'b00;
        end else begin
            clk_sync_q <= {clk_sync_q[0], ps2_clk};
            dat_sync_q <= {dat_sync_q[0], ps2_data};
        end
    end

    // Glitch filter: the filtered clock follows only after FILTER_LEN equal samples.
    always_ff @(posedge pclk) begin
        if (rst) begin
            filt_q      <= 1'b1;
            filt_prev_q <= 1'b1;
            filt_cnt_q  <= '0;
        end else begin
            filt_prev_q <= filt_q;
            if (clk_sync_q[1] == filt_q) begin
                filt_cnt_q <= '0;
            end else if (filt_cnt_q == FILT_LAST) begin
                filt_q     <= clk_sync_q[1];
                filt_cnt_q <= '0;
            end else begin
                filt_cnt_q <= filt_cnt_q + FW'(1);
            end
        end
    end

    assign strobe = filt_prev_q & ~filt_q;

    // Stop bit high and odd parity across data plus parity bit.
    assign frame_ok = shift_q[9] & (^shift_q[8:0]);

    // Frame FSM with timeout; result pulses are registered.
    always_ff @(posedge pclk) begin
        if (rst) begin
            state_q    <= RX_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            timer_q    <= '0;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
            case (state_q)
                RX_IDLE: begin
                    timer_q   <= '0;
                    bit_cnt_q <= 4'd0;
                    if (strobe) begin
                        if (dat_sync_q[1]) begin
                            // Bad start bit: reject and keep waiting.
                            rx_err_q <= 1'b1;
                        end else begin
                            state_q   <= RX_RECV;
                            bit_cnt_q <= 4'd1;
                        end
                    end
                end
                RX_RECV: begin
                    if (strobe) begin
                        shift_q <= {dat_sync_q[1], shift_q[9:1]};
                        timer_q <= '0;
                        if (bit_cnt_q == 4'd10) begin
                            state_q <= RX_CHECK;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end else if (timer_q == TIMEOUT_MAX) begin
                        // Keyboard stalled mid-frame: abandon it.
                        rx_err_q <= 1'b1;
                        state_q  <= RX_IDLE;
                    end else begin
                        timer_q <= timer_q + TW'(1);
                    end
                end
                RX_CHECK: begin
                    if (frame_ok) begin
                        rx_data_q  <= shift_q[7:0];
                        rx_valid_q <= 1'b1;
                    end else begin
                        rx_err_q <= 1'b1;
                    end
                    state_q   <= RX_IDLE;
                    bit_cnt_q <= 4'd0;
                end
                default: begin
                    state_q <= RX_IDLE;
                end
            endcase
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Keyboard front end for car_ctl: receives PS/2 bytes and keeps a bitmap of
// held steering keys (arrows and WASD share the four direction bits).
module ps2_key_decoder
    import car_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic pclk,
    input  logic rst,
    ps2_key_decoder_if.slave bus
);

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_err;

    logic [3:0] key_q, key_d;
    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [3:0] hit;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .pclk    (pclk),
        .rst     (rst),
        .ps2_clk (bus.ps2_clk),
        .ps2_data(bus.ps2_data),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    assign hit = key_lookup(ext_q, rx_data);

    // Scan decoding: prefixes set flags, any other byte consumes them.
    always_comb begin
        key_d = key_q;
        ext_d = ext_q;
        brk_d = brk_q;
        if (rx_valid) begin
            if (rx_data == SC_EXT) begin
                ext_d = 1'b1;
            end else if (rx_data == SC_BRK) begin
                brk_d = 1'b1;
            end else begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                if (rx_data == SC_OVR0 || rx_data == SC_OVR1) begin
                    key_d = 4'b0000;
                end else if (brk_q) begin
                    key_d = key_q & ~hit;
                end else begin
                    key_d = key_q | hit;
                end
            end
        end
    end

    // Key bitmap and prefix flags.
    always_ff @(posedge pclk) begin
        if (rst) begin
            key_q <= 4'b0000;
            ext_q <= 1'b0;
            brk_q <= 1'b0;
        end else begin
            key_q <= key_d;
            ext_q <= ext_d;
            brk_q <= brk_d;
        end
    end

    assign bus.key      = key_q;
    assign bus.rx_data  = rx_data;
    assign bus.rx_valid = rx_valid;
    assign bus.rx_err   = rx_err;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a PS/2 bus model drives frames, a monitor counts
// result pulses every cycle, and a byte-level model of held keys predicts key.
module tb_ps2_key_decoder;
    import car_pkg::*;

    localparam int FILT = 8;
    localparam int TOUT = 200;
    localparam int HALF = 20;   // pclk cycles per half bus-clock period

    logic pclk = 1'b0;
    logic rst  = 1'b1;

    ps2_key_decoder_if bus();

    ps2_key_decoder #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TOUT)
    ) dut (
        .pclk(pclk),
        .rst (rst),
        .bus (bus)
    );

    always #5 pclk = ~pclk;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    always @(posedge pclk) cyc <= cyc + 1;

    // Per-cycle monitor of the result pulses and key stability.
    int         n_valid = 0;
    int         n_err = 0;
    int         spurious = 0;
    int         last_err_cyc = 0;
    logic       prev_valid = 1'b0;
    logic [3:0] prev_key = 4'b0000;
    always @(negedge pclk) begin
        if (bus.rx_valid === 1'b1) n_valid <= n_valid + 1;
        if (bus.rx_err === 1'b1) begin
            n_err        <= n_err + 1;
            last_err_cyc <= cyc;
        end
        if (!rst && bus.key !== prev_key && !prev_valid) spurious <= spurious + 1;
        if (!rst && bus.rx_valid === 1'b1 && prev_valid) spurious <= spurious + 1;
        prev_valid <= bus.rx_valid;
        prev_key   <= bus.key;
    end

    int last_fall_cyc = 0;

    // Behavioural model: which directions are held, and the pending prefixes.
    logic       m_ext = 1'b0;
    logic       m_brk = 1'b0;
    logic [3:0] m_key = 4'b0000;
    logic [7:0] exp_data = 8'h00;

    function automatic int dir_index(input logic ext, input logic [7:0] b);
        logic [7:0] codes [4];
        if (ext) codes = '{8'h75, 8'h72, 8'h6B, 8'h74};
        else     codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int i = 0; i < 4; i++) if (codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int d;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            if (b == 8'h00 || b == 8'hFF) m_key = 4'b0000;
            else begin
                d = dir_index(m_ext, b);
                if (d >= 0) m_key[d] = !m_brk;
            end
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_ext = 1'b0;
        m_brk = 1'b0;
        m_key = 4'b0000;
        exp_data = 8'h00;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge pclk);
    endtask

    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad);
        logic p;
        p = ~(^b) ^ bad;
        return {1'b1, p, b, 1'b0};
    endfunction

    // Drive nbits of a frame; with glitch set, short pulses land in both phases.
    task automatic send_bits(input logic [10:0] fr, input int nbits, input bit glitch);
        int g;
        for (int i = 0; i < nbits; i++) begin
            bus.ps2_data = fr[i];
            if (glitch) begin
                cycles(4);
                g = $urandom_range(1, FILT - 2);
                bus.ps2_clk = 1'b0;
                cycles(g);
                bus.ps2_clk = 1'b1;
                cycles(HALF - 4 - g);
            end else begin
                cycles(HALF);
            end
            bus.ps2_clk = 1'b0;
            last_fall_cyc = cyc;
            if (glitch) begin
                cycles(12);
                g = $urandom_range(1, FILT - 2);
                bus.ps2_clk = 1'b1;
                cycles(g);
                bus.ps2_clk = 1'b0;
                cycles(HALF - 12 - g);
            end else begin
                cycles(HALF);
            end
            bus.ps2_clk = 1'b1;
        end
        bus.ps2_data = 1'b1;
    endtask

    // One full frame, model update and checks of pulses, data and key.
    task automatic run_frame(input string nm, input logic [7:0] b, input bit bad,
                             input bit glitch, input bit use_tab, input logic [3:0] tab_key);
        int v0;
        int e0;
        int k;
        v0 = n_valid;
        e0 = n_err;
        send_bits(make_frame(b, bad), 11, glitch);
        k = 0;
        while (k < 60 && n_valid == v0 && n_err == e0) begin
            cycles(1);
            k++;
        end
        cycles(4);
        if (!bad) begin
            exp_data = b;
            model_byte(b);
        end
        chk({nm, " rx_valid count"}, n_valid - v0, bad ? 0 : 1);
        chk({nm, " rx_err count"}, n_err - e0, bad ? 1 : 0);
        chk({nm, " rx_data"}, bus.rx_data, exp_data);
        chk({nm, " key"}, bus.key, use_tab ? tab_key : m_key);
        $display("frame %s byte=%02h bad=%0d glitch=%0d key=%b rx_data=%02h",
                 nm, b, bad, glitch, bus.key, bus.rx_data);
    endtask

    typedef struct {
        logic [7:0] code;
        bit         bad;
        logic [3:0] exp_key;
    } vec_t;

    vec_t vecs [15];

    initial begin
        int v0;
        int e0;
        int k;
        int delta;
        logic [7:0] b;
        logic [7:0] pick [8];
        int r;

        vecs[0]  = '{8'hE0, 1'b0, 4'b0000};
        vecs[1]  = '{8'h75, 1'b0, 4'b0001};
        vecs[2]  = '{8'hE0, 1'b0, 4'b0001};
        vecs[3]  = '{8'hF0, 1'b0, 4'b0001};
        vecs[4]  = '{8'h75, 1'b0, 4'b0000};
        vecs[5]  = '{8'h1C, 1'b0, 4'b0100};
        vecs[6]  = '{8'hE0, 1'b0, 4'b0100};
        vecs[7]  = '{8'h74, 1'b0, 4'b1100};
        vecs[8]  = '{8'hF0, 1'b0, 4'b1100};
        vecs[9]  = '{8'h1C, 1'b0, 4'b1000};
        vecs[10] = '{8'h1D, 1'b1, 4'b1000};
        vecs[11] = '{8'h1D, 1'b0, 4'b1001};
        vecs[12] = '{8'h1D, 1'b0, 4'b1001};
        vecs[13] = '{8'hF0, 1'b0, 4'b1001};
        vecs[14] = '{8'h1B, 1'b0, 4'b1001};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        rst = 1'b1;
        cycles(5);
        chk("reset key", bus.key, 4'b0000);
        chk("reset rx_data", bus.rx_data, 8'h00);
        chk("reset rx_valid", bus.rx_valid, 1'b0);
        chk("reset rx_err", bus.rx_err, 1'b0);
        rst = 1'b0;
        cycles(20);

        // Directed make/break sequences, bad parity, typematic repeat, stray release.
        for (int i = 0; i < 15; i++) begin
            run_frame($sformatf("vec%0d", i), vecs[i].code, vecs[i].bad, 1'b0, 1'b1, vecs[i].exp_key);
        end

        // Frame abandoned after 5 bits: rx_err once the timeout elapses.
        v0 = n_valid;
        e0 = n_err;
        send_bits(make_frame(8'h5A, 1'b0), 5, 1'b0);
        k = 0;
        while (k < TOUT + 100 && n_err == e0) begin
            cycles(1);
            k++;
        end
        delta = last_err_cyc - last_fall_cyc;
        chk("timeout rx_err count", n_err - e0, 1);
        chk("timeout no rx_valid", n_valid - v0, 0);
        chk("timeout latency in window", (delta >= TOUT && delta <= TOUT + FILT + 8) ? 1 : 0, 1);
        chk("timeout key unchanged", bus.key, 4'b1001);
        $display("timeout delta=%0d cycles after last clock fall", delta);
        cycles(10);
        run_frame("after_timeout_23", 8'h23, 1'b0, 1'b0, 1'b1, 4'b1001);

        // Glitchy clock mid-frame must not disturb reception.
        run_frame("glitch_E0", 8'hE0, 1'b0, 1'b1, 1'b1, 4'b1001);
        run_frame("glitch_72", 8'h72, 1'b0, 1'b1, 1'b1, 4'b1011);

        // Overrun code clears held keys, then reset in the middle of a frame.
        run_frame("overrun_FF", 8'hFF, 1'b0, 1'b0, 1'b1, 4'b0000);
        run_frame("hold_W", 8'h1D, 1'b0, 1'b0, 1'b1, 4'b0001);
        v0 = n_valid;
        send_bits(make_frame(8'h1B, 1'b0), 5, 1'b0);
        rst = 1'b1;
        cycles(3);
        rst = 1'b0;
        model_reset();
        cycles(HALF * 6);
        chk("rst midframe no rx_valid", n_valid - v0, 0);
        chk("rst midframe key", bus.key, 4'b0000);
        chk("rst midframe rx_data", bus.rx_data, 8'h00);
        run_frame("post_rst_1D", 8'h1D, 1'b0, 1'b0, 1'b1, 4'b0001);

        // Randomised byte stream against the model.
        pick = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h1D, 8'h1B, 8'h1C, 8'h23};
        for (int i = 0; i < 50; i++) begin
            r = $urandom_range(0, 15);
            if (r < 7)       b = pick[$urandom_range(0, 7)];
            else if (r < 10) b = 8'hE0;
            else if (r < 13) b = 8'hF0;
            else if (r < 15) b = 8'($urandom_range(0, 255));
            else             b = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            run_frame($sformatf("rand%0d", i), b, ($urandom_range(0, 9) == 0), 1'b0, 1'b0, 4'b0000);
        end

        chk("no stray key change or long pulse", spurious, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
